// File: rtl/spike_train_monitor_pkg.sv
// Shared types and constants for the spike train monitor and its record FIFO.
package spike_train_monitor_pkg;

   localparam logic [7:0] ISI_NONE  = 8'd255;
   localparam logic [7:0] COUNT_MAX = 8'd255;

   typedef struct packed {
      logic [7:0] count;
      logic [7:0] isi_min;
   } spike_rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mon_state_t;

endpackage

// File: rtl/spike_rec_fifo.sv
// Small synchronous FIFO for window records; pointer-based with one extra wrap bit.
module spike_rec_fifo
   import spike_train_monitor_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type rec_t = spike_rec_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  rec_t push_data,
   input  logic pop,
   output rec_t head,
   output logic not_empty,
   output logic full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   rec_t        mem [DEPTH];
   logic        empty;
   logic        do_pop;
   logic        do_push;

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign not_empty = !empty;
   assign do_pop    = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push   = push && (!full || do_pop);
   assign head      = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Read/write pointer advance; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Record storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/spike_train_monitor.sv
// Counts spike rising edges and the shortest inter-spike interval per fixed window,
// queuing one {count, isi_min} record per completed window.
module spike_train_monitor
   import spike_train_monitor_pkg::*;
#(
   parameter int WIN_LOG2   = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       spike,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_count,
   output logic [7:0] out_isi_min,
   output logic       overflow
);

   mon_state_t          state;
   mon_state_t          state_nxt;
   logic                spike_prev;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [7:0]          ev_count;
   logic [7:0]          isi_min;
   logic [7:0]          isi_cnt;
   logic                armed;
   logic                active;
   logic                event_hit;
   logic                win_last;
   logic [7:0]          count_incl;
   logic [7:0]          isi_incl;
   spike_rec_t          rec_new;
   spike_rec_t          head;
   logic                fifo_full;
   logic                fifo_pop;
   logic                drop;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == COUNT_MAX) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
      return (a < b) ? a : b;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state: enable alone decides between idle and running.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (en)  state_nxt = ST_RUN;
         ST_RUN:  if (!en) state_nxt = ST_IDLE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // A cycle only contributes to a window while running and still enabled.
   assign active     = (state == ST_RUN) && en;
   assign event_hit  = active && spike && !spike_prev;
   assign win_last   = active && (&win_cnt);
   assign count_incl = event_hit ? sat_inc8(ev_count) : ev_count;
   assign isi_incl   = (event_hit && armed) ? min8(isi_min, isi_cnt) : isi_min;
   assign rec_new    = '{count: count_incl, isi_min: isi_incl};

   // Previous spike sample for edge detection; forgotten whenever disabled.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) spike_prev <= 1'b0;
      else               spike_prev <= spike;
   end

   // Window and interval tracking; idling clears everything so a new run starts fresh.
   always_ff @(posedge clk) begin
      if (!rst_n || !active) begin
         win_cnt  <= '0;
         ev_count <= 8'd0;
         isi_min  <= ISI_NONE;
         isi_cnt  <= 8'd0;
         armed    <= 1'b0;
      end else begin
         win_cnt <= win_cnt + 1'b1;
         if (win_last) begin
            ev_count <= 8'd0;
            isi_min  <= ISI_NONE;
         end else begin
            ev_count <= count_incl;
            isi_min  <= isi_incl;
         end
         // Interval counter spans window boundaries; it restarts at 1 after each event.
         isi_cnt <= event_hit ? 8'd1 : sat_inc8(isi_cnt);
         armed   <= armed | event_hit;
      end
   end

   assign fifo_pop = out_valid && out_ready;
   assign drop     = win_last && fifo_full && !fifo_pop;

   // Sticky drop indicator, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

   spike_rec_fifo #(
      .DEPTH (FIFO_DEPTH),
      .rec_t (spike_rec_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (win_last),
      .push_data (rec_new),
      .pop       (fifo_pop),
      .head      (head),
      .not_empty (out_valid),
      .full      (fifo_full)
   );

   assign out_count   = head.count;
   assign out_isi_min = head.isi_min;

endmodule

// File: tb/tb_spike_train_monitor.sv
// Randomized + directed bench for spike_train_monitor with an event-time reference model.
module tb_spike_train_monitor;
   import spike_train_monitor_pkg::*;

   localparam int WIN_LOG2 = 4;
   localparam int WIN      = 16;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       spike = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_count;
   logic [7:0] out_isi_min;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   spike_rec_t exp_q[$];

   // Reference model state: absolute cycle number, event times since entering RUN.
   int t = 0;
   bit m_run = 0;
   bit m_prev = 0;
   int win_start = 0;
   int ev_times[$];
   int occ = 0;
   bit m_ovf = 0;

   spike_train_monitor #(
      .WIN_LOG2   (WIN_LOG2),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .spike       (spike),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_count   (out_count),
      .out_isi_min (out_isi_min),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Window summary from the list of event times: count of events in [lo,hi] and the
   // smallest gap from each of them to the preceding event since RUN entry.
   function automatic spike_rec_t window_record(input int lo, input int hi);
      spike_rec_t r;
      int n = 0;
      int best = 255;
      for (int i = 0; i < ev_times.size(); i++) begin
         if (ev_times[i] >= lo && ev_times[i] <= hi) begin
            n++;
            if (i > 0 && (ev_times[i] - ev_times[i-1]) < best) best = ev_times[i] - ev_times[i-1];
         end
      end
      r.count   = (n > 255) ? 8'd255 : 8'(n);
      r.isi_min = 8'(best);
      return r;
   endfunction

   task automatic model_edge();
      bit pop_m;
      bit push_m;
      int pos;
      spike_rec_t r;
      push_m = 0;
      r = '0;
      t++;
      if (!rst_n) begin
         m_run = 0; m_prev = 0; occ = 0; m_ovf = 0;
         exp_q.delete(); ev_times.delete();
         return;
      end
      pop_m = (occ > 0) && out_ready;
      if (m_run && en) begin
         pos = t - win_start;
         if (spike && !m_prev) ev_times.push_back(t);
         if (pos % WIN == WIN - 1) begin
            r = window_record(t - WIN + 1, t);
            push_m = 1;
         end
      end
      if (!m_run) begin
         if (en) begin
            m_run = 1;
            win_start = t + 1;
            ev_times.delete();
         end
      end else if (!en) begin
         m_run = 0;
      end
      m_prev = en ? spike : 1'b0;
      if (push_m) begin
         if (occ == DEPTH && !pop_m) m_ovf = 1;
         else begin
            exp_q.push_back(r);
            occ++;
         end
      end
      if (pop_m) occ--;
   endtask

   task automatic cyc(input bit e, input bit s, input bit r, input bit rn = 1'b1);
      en = e; spike = s; out_ready = r; rst_n = rn;
      @(posedge clk);
      model_edge();
      #1;
      check("out_valid", out_valid, (occ > 0) ? 1 : 0);
      check("overflow", overflow, m_ovf);
      if (occ == 0) begin
         check("empty_count", out_count, 0);
         check("empty_isi_min", out_isi_min, 0);
      end
   endtask

   task automatic window(input logic [15:0] pat, input bit r, input bit r_last);
      for (int p = 0; p < WIN; p++) cyc(1'b1, pat[p], (p == WIN - 1) ? r_last : r);
   endtask

   // Monitor: every accepted record must match the oldest expected record.
   always @(negedge clk) begin
      spike_rec_t e;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_record", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("rec_count", out_count, e.count);
            check("rec_isi_min", out_isi_min, e.isi_min);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0);

      // Pulses at window cycles 2, 5, 11.
      cyc(1, 0, 1);
      window(16'h0824, 1'b1, 1'b1);
      check("req030_valid", out_valid, 1);
      check("req030_count", out_count, 3);
      check("req030_isi_min", out_isi_min, 3);

      // Spike held high 3..9 after a fresh RUN entry: one edge, no interval.
      cyc(0, 0, 1);
      cyc(1, 0, 1);
      window(16'h03F8, 1'b1, 1'b1);
      check("req031_count", out_count, 1);
      check("req031_isi_min", out_isi_min, 255);

      // Six windows without a consumer, then drain.
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      cyc(1, 0, 0);
      for (int w = 0; w < 6; w++) window(16'($urandom), 1'b0, 1'b0);
      check("req032_overflow", overflow, 1);
      check("req032_occupancy", occ, 4);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);
      check("req032_drained", out_valid, 0);

      // Full FIFO, consumer ready exactly on the push cycle.
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0);
      for (int w = 0; w < 4; w++) window(16'($urandom), 1'b0, 1'b0);
      window(16'($urandom), 1'b0, 1'b1);
      check("req033_overflow", overflow, 0);
      check("req033_occupancy", occ, 4);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1);

      // Enable dropped at window cycle 9 after two events, then re-raised.
      cyc(1, 0, 1);
      for (int p = 0; p < 9; p++) cyc(1, (p == 1 || p == 4), 1);
      cyc(0, 0, 1);
      cyc(1, 0, 1);
      window(16'h0040, 1'b1, 1'b1);
      check("req034_count", out_count, 1);
      check("req034_isi_min", out_isi_min, 255);

      // Reset with two queued records and no consumer.
      cyc(0, 0, 1);
      cyc(1, 0, 0);
      window(16'h0011, 1'b0, 1'b0);
      window(16'h0101, 1'b0, 1'b0);
      check("req035_queued", occ, 2);
      cyc(1, 0, 0, 0);
      check("req035_valid", out_valid, 0);
      check("req035_overflow", overflow, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) < 97, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 999) != 0);

      for (int i = 0; i < 8; i++) cyc(0, 0, 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
